// File: rtl/rs_issue_pool_pkg.sv
// rs_issue_pool_pkg: constants shared by the ALU/branch reservation station
// and its neighbours. This file holds the default tag and opcode widths, the
// null tag and the opcode encodings.
package rs_issue_pool_pkg;

  localparam int RS_ROB_W = 4;
  localparam int RS_OP_W  = 6;

  // A ROB tag of zero means "operand already available" or "no broadcast".
  localparam logic [RS_ROB_W-1:0] NULL_TAG = '0;

  localparam logic [RS_OP_W-1:0] OP_NOP  = 6'h00;
  localparam logic [RS_OP_W-1:0] OP_ADD  = 6'h01;
  localparam logic [RS_OP_W-1:0] OP_SUB  = 6'h02;
  localparam logic [RS_OP_W-1:0] OP_AND  = 6'h03;
  localparam logic [RS_OP_W-1:0] OP_OR   = 6'h04;
  localparam logic [RS_OP_W-1:0] OP_XOR  = 6'h05;
  localparam logic [RS_OP_W-1:0] OP_SLL  = 6'h06;
  localparam logic [RS_OP_W-1:0] OP_SRL  = 6'h07;
  localparam logic [RS_OP_W-1:0] OP_SRA  = 6'h08;
  localparam logic [RS_OP_W-1:0] OP_SLT  = 6'h09;
  localparam logic [RS_OP_W-1:0] OP_SLTU = 6'h0a;
  localparam logic [RS_OP_W-1:0] OP_BEQ  = 6'h0b;
  localparam logic [RS_OP_W-1:0] OP_BNE  = 6'h0c;
  localparam logic [RS_OP_W-1:0] OP_BLT  = 6'h0d;
  localparam logic [RS_OP_W-1:0] OP_BGE  = 6'h0e;
  localparam logic [RS_OP_W-1:0] OP_JAL  = 6'h0f;
  localparam logic [RS_OP_W-1:0] OP_JALR = 6'h10;
  localparam logic [RS_OP_W-1:0] OP_LUI  = 6'h11;

endpackage

// File: rtl/rs_issue_pool_age.sv
// rs_age_select: age matrix and oldest-ready picker for the reservation station.
//   clk_in, rst_in : clock, synchronous active-high reset
//   en_in          : global enable; matrix holds when low
//   flush_in       : clears the whole matrix (only effective with en_in)
//   busy_in        : registered busy vector of the station
//   alloc_in       : one-hot entry being allocated this edge (or zero)
//   free_in        : one-hot entry being freed by issue this edge (or zero)
//   ready_in       : registered ready vector
//   grant_out      : one-hot oldest ready entry (zero when none is ready)
module rs_age_select import rs_issue_pool_pkg::*; #(
  parameter int ENTRIES = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  input  logic               flush_in,
  input  logic [ENTRIES-1:0] busy_in,
  input  logic [ENTRIES-1:0] alloc_in,
  input  logic [ENTRIES-1:0] free_in,
  input  logic [ENTRIES-1:0] ready_in,
  output logic [ENTRIES-1:0] grant_out
);

  // older_q[i][j] set: entry j was allocated before entry i.
  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];

  always_comb begin
    for (int r = 0; r < ENTRIES; r++) begin
      older_d[r] = older_q[r];
    end
    if (en_in) begin
      for (int r = 0; r < ENTRIES; r++) begin
        if (flush_in) begin
          older_d[r] = '0;
        end else begin
          // Columns of entries leaving or (re)entering no longer order anyone.
          older_d[r] = older_q[r] & ~alloc_in & ~free_in;
          // A new entry is younger than everything that stays busy.
          if (alloc_in[r]) begin
            older_d[r] = busy_in & ~free_in;
          end
        end
      end
    end
  end

  // Entry i wins when no other ready entry is older than it.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_pick
    assign grant_out[gi] = ready_in[gi] && ((ready_in & older_q[gi]) == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < ENTRIES; r++) begin
        older_q[r] <= '0;
      end
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/rs_issue_pool.sv
// rs_issue_pool: N-entry reservation station for the ALU/branch path with
// multi-port CDB wakeup and oldest-first issue into a valid/ready register.
//   clk_in, rst_in, rdy_in, flush_in : clock, sync reset, global enable, flush
//   disp_*                           : dispatch request and payload
//   disp_rdy_out                     : a free entry exists
//   cdb_tag_in, cdb_val_in           : packed broadcast ports
//   iss_*                            : issue register with valid/ready handshake
//   count_out                        : busy entries (issue register excluded)
module rs_issue_pool import rs_issue_pool_pkg::*; #(
  parameter int ENTRIES   = 8,
  parameter int CDB_PORTS = 2,
  parameter int ROB_W     = RS_ROB_W,
  parameter int XLEN      = 32,
  parameter int OP_W      = RS_OP_W
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      disp_en_in,
  output logic                      disp_rdy_out,
  input  logic [OP_W-1:0]           disp_op_in,
  input  logic [ROB_W-1:0]          disp_qj_in,
  input  logic [ROB_W-1:0]          disp_qk_in,
  input  logic [XLEN-1:0]           disp_vj_in,
  input  logic [XLEN-1:0]           disp_vk_in,
  input  logic [XLEN-1:0]           disp_imm_in,
  input  logic [XLEN-1:0]           disp_pc_in,
  input  logic [ROB_W-1:0]          disp_dest_in,
  input  logic [CDB_PORTS*ROB_W-1:0] cdb_tag_in,
  input  logic [CDB_PORTS*XLEN-1:0]  cdb_val_in,
  output logic                      iss_valid_out,
  input  logic                      iss_ready_in,
  output logic [OP_W-1:0]           iss_op_out,
  output logic [XLEN-1:0]           iss_vj_out,
  output logic [XLEN-1:0]           iss_vk_out,
  output logic [XLEN-1:0]           iss_imm_out,
  output logic [XLEN-1:0]           iss_pc_out,
  output logic [ROB_W-1:0]          iss_dest_out,
  output logic [$clog2(ENTRIES):0]  count_out
);

  localparam int CNT_W = $clog2(ENTRIES) + 1;
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q  [ENTRIES], op_d  [ENTRIES];
  logic [ROB_W-1:0]   qj_q  [ENTRIES], qj_d  [ENTRIES];
  logic [ROB_W-1:0]   qk_q  [ENTRIES], qk_d  [ENTRIES];
  logic [XLEN-1:0]    vj_q  [ENTRIES], vj_d  [ENTRIES];
  logic [XLEN-1:0]    vk_q  [ENTRIES], vk_d  [ENTRIES];
  logic [XLEN-1:0]    imm_q [ENTRIES], imm_d [ENTRIES];
  logic [XLEN-1:0]    pc_q  [ENTRIES], pc_d  [ENTRIES];
  logic [ROB_W-1:0]   dest_q[ENTRIES], dest_d[ENTRIES];

  logic             iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]  iss_op_q, iss_op_d;
  logic [XLEN-1:0]  iss_vj_q, iss_vj_d, iss_vk_q, iss_vk_d;
  logic [XLEN-1:0]  iss_imm_q, iss_imm_d, iss_pc_q, iss_pc_d;
  logic [ROB_W-1:0] iss_dest_q, iss_dest_d;

  logic [ROB_W-1:0] cdb_tag [CDB_PORTS];
  logic [XLEN-1:0]  cdb_val [CDB_PORTS];
  for (genvar gi = 0; gi < CDB_PORTS; gi++) begin : g_cdb
    assign cdb_tag[gi] = cdb_tag_in[gi*ROB_W +: ROB_W];
    assign cdb_val[gi] = cdb_val_in[gi*XLEN +: XLEN];
  end

  logic [ENTRIES-1:0] ready_vec, grant_vec, alloc_vec, alloc_fire, free_fire;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   sel_idx;
  logic               disp_fire, iss_load, issue_fire;
  logic [ROB_W-1:0]   byp_qj, byp_qk;
  logic [XLEN-1:0]    byp_vj, byp_vk;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ready
    assign ready_vec[gi] = busy_q[gi] && (qj_q[gi] == NULL_TAG[ROB_W-1:0] || ROB_W != RS_ROB_W && qj_q[gi] == '0)
                           && (qk_q[gi] == '0);
  end

  always_comb begin
    alloc_vec = '0;
    count     = '0;
    sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_vec    = '0;
        alloc_vec[i] = 1'b1;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      count = count + CNT_W'(busy_q[i]);
      if (grant_vec[i]) sel_idx = IDX_W'(i);
    end
  end

  // A freed entry is only visible to dispatch from the next cycle on.
  assign disp_rdy_out = (count != CNT_W'(ENTRIES));
  assign disp_fire    = rdy_in && !flush_in && disp_en_in && disp_rdy_out;
  assign iss_load     = !iss_valid_q || iss_ready_in;
  assign issue_fire   = rdy_in && !flush_in && iss_load && (grant_vec != '0);
  assign alloc_fire   = disp_fire  ? alloc_vec : '0;
  assign free_fire    = issue_fire ? grant_vec : '0;

  rs_age_select #(.ENTRIES(ENTRIES)) u_age (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (rdy_in),
    .flush_in  (flush_in),
    .busy_in   (busy_q),
    .alloc_in  (alloc_fire),
    .free_in   (free_fire),
    .ready_in  (ready_vec),
    .grant_out (grant_vec)
  );

  // Same-cycle CDB bypass for the dispatched operands; port loop runs high to
  // low so the lowest matching port has the final word.
  always_comb begin
    byp_qj = disp_qj_in;
    byp_vj = disp_vj_in;
    byp_qk = disp_qk_in;
    byp_vk = disp_vk_in;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_tag[p] != '0 && cdb_tag[p] == disp_qj_in) begin
        byp_qj = '0;
        byp_vj = cdb_val[p];
      end
      if (cdb_tag[p] != '0 && cdb_tag[p] == disp_qk_in) begin
        byp_qk = '0;
        byp_vk = cdb_val[p];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    op_d = op_q;   qj_d = qj_q;   qk_d = qk_q;   vj_d = vj_q;
    vk_d = vk_q;   imm_d = imm_q; pc_d = pc_q;   dest_d = dest_q;
    iss_valid_d = iss_valid_q;
    iss_op_d  = iss_op_q;  iss_vj_d = iss_vj_q;  iss_vk_d   = iss_vk_q;
    iss_imm_d = iss_imm_q; iss_pc_d = iss_pc_q;  iss_dest_d = iss_dest_q;
    if (rdy_in) begin
      if (flush_in) begin
        busy_d      = '0;
        iss_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (busy_q[i] && cdb_tag[p] != '0 && cdb_tag[p] == qj_q[i]) begin
              qj_d[i] = '0;
              vj_d[i] = cdb_val[p];
            end
            if (busy_q[i] && cdb_tag[p] != '0 && cdb_tag[p] == qk_q[i]) begin
              qk_d[i] = '0;
              vk_d[i] = cdb_val[p];
            end
          end
          if (alloc_fire[i]) begin
            op_d[i]  = disp_op_in;   qj_d[i] = byp_qj;      qk_d[i]   = byp_qk;
            vj_d[i]  = byp_vj;       vk_d[i] = byp_vk;      imm_d[i]  = disp_imm_in;
            pc_d[i]  = disp_pc_in;   dest_d[i] = disp_dest_in;
          end
        end
        busy_d = (busy_q & ~free_fire) | alloc_fire;
        if (iss_load) begin
          iss_valid_d = issue_fire;
          if (issue_fire) begin
            iss_op_d  = op_q[sel_idx];  iss_vj_d = vj_q[sel_idx];  iss_vk_d   = vk_q[sel_idx];
            iss_imm_d = imm_q[sel_idx]; iss_pc_d = pc_q[sel_idx];  iss_dest_d = dest_q[sel_idx];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= OP_W'(OP_NOP);
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      iss_dest_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_vj_q    <= iss_vj_d;
      iss_vk_q    <= iss_vk_d;
      iss_imm_q   <= iss_imm_d;
      iss_pc_q    <= iss_pc_d;
      iss_dest_q  <= iss_dest_d;
    end
  end

  // Payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    op_q <= op_d;   qj_q <= qj_d;   qk_q <= qk_d;   vj_q <= vj_d;
    vk_q <= vk_d;   imm_q <= imm_d; pc_q <= pc_d;   dest_q <= dest_d;
  end

  assign iss_valid_out = iss_valid_q;
  assign iss_op_out    = iss_op_q;
  assign iss_vj_out    = iss_vj_q;
  assign iss_vk_out    = iss_vk_q;
  assign iss_imm_out   = iss_imm_q;
  assign iss_pc_out    = iss_pc_q;
  assign iss_dest_out  = iss_dest_q;
  assign count_out     = count;

endmodule
